// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitch pulse generator.
package glitch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        PULSE,
        GAP
    } state_t;

    localparam logic [1:0] SEL_DELAY  = 2'd0;
    localparam logic [1:0] SEL_WIDTH  = 2'd1;
    localparam logic [1:0] SEL_GAP    = 2'd2;
    localparam logic [1:0] SEL_REPEAT = 2'd3;

    localparam int DEF_DELAY_W  = 32;
    localparam int DEF_WIDTH_W  = 16;
    localparam int DEF_REPEAT_W = 8;

endpackage

// File: rtl/glitch_prog_regs.sv
// Four serially loaded timing registers (MSB first); loading is only
// possible while the generator is idle.
module glitch_prog_regs
    import glitch_pkg::*;
#(
    parameter int DELAY_W    = DEF_DELAY_W,
    parameter int WIDTH_W    = DEF_WIDTH_W,
    parameter int REPEAT_W   = DEF_REPEAT_W,
    parameter int DEF_DELAY  = 0,
    parameter int DEF_WIDTH  = 4,
    parameter int DEF_GAP    = 1,
    parameter int DEF_REPEAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic [1:0]          sel,
    input  logic                bit_in,
    output logic [DELAY_W-1:0]  delay,
    output logic [WIDTH_W-1:0]  width,
    output logic [WIDTH_W-1:0]  gap,
    output logic [REPEAT_W-1:0] rpt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay <= DELAY_W'(DEF_DELAY);
            width <= WIDTH_W'(DEF_WIDTH);
            gap   <= WIDTH_W'(DEF_GAP);
            rpt   <= REPEAT_W'(DEF_REPEAT);
        end else if (shift_en) begin
            case (sel)
                SEL_DELAY:  delay <= {delay[DELAY_W-2:0], bit_in};
                SEL_WIDTH:  width <= {width[WIDTH_W-2:0], bit_in};
                SEL_GAP:    gap   <= {gap[WIDTH_W-2:0], bit_in};
                SEL_REPEAT: rpt   <= {rpt[REPEAT_W-2:0], bit_in};
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/glitch_pulse_gen.sv
// Armed trigger-edge driven glitch pulse train: delay, then repeat x
// (width high, gap low), with the final gap replaced by a done strobe.
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int DELAY_W    = DEF_DELAY_W,
    parameter int WIDTH_W    = DEF_WIDTH_W,
    parameter int REPEAT_W   = DEF_REPEAT_W,
    parameter int DEF_DELAY  = 0,
    parameter int DEF_WIDTH  = 4,
    parameter int DEF_GAP    = 1,
    parameter int DEF_REPEAT = 1
) (
    input  logic       sc_clk,
    input  logic       sc_reset,
    input  logic       trigger,
    input  logic       arm,
    input  logic       abort,
    input  logic       prog_shift,
    input  logic [1:0] prog_sel,
    input  logic       prog_bit,
    output logic       glitch_out,
    output logic       armed,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    state_t              state;
    logic                trig_q;
    logic                trig_edge;
    logic [CNT_W-1:0]    cnt;
    logic [REPEAT_W-1:0] pcnt;
    logic [REPEAT_W:0]   pcnt_nxt;
    logic                last_pulse;

    logic [DELAY_W-1:0]  delay_reg;
    logic [WIDTH_W-1:0]  width_reg, gap_reg, width_c, gap_c, eff_width, eff_gap;
    logic [REPEAT_W-1:0] repeat_reg, repeat_c, eff_repeat;

    glitch_prog_regs #(
        .DELAY_W    (DELAY_W),
        .WIDTH_W    (WIDTH_W),
        .REPEAT_W   (REPEAT_W),
        .DEF_DELAY  (DEF_DELAY),
        .DEF_WIDTH  (DEF_WIDTH),
        .DEF_GAP    (DEF_GAP),
        .DEF_REPEAT (DEF_REPEAT)
    ) u_regs (
        .clk      (sc_clk),
        .rst      (sc_reset),
        .shift_en (prog_shift && (state == IDLE)),
        .sel      (prog_sel),
        .bit_in   (prog_bit),
        .delay    (delay_reg),
        .width    (width_reg),
        .gap      (gap_reg),
        .rpt      (repeat_reg)
    );

    // Zero in width/gap/repeat means one.
    assign width_c  = (width_reg  == '0) ? WIDTH_W'(1)  : width_reg;
    assign gap_c    = (gap_reg    == '0) ? WIDTH_W'(1)  : gap_reg;
    assign repeat_c = (repeat_reg == '0) ? REPEAT_W'(1) : repeat_reg;

    assign trig_edge  = trigger && !trig_q;
    assign pcnt_nxt   = {1'b0, pcnt} + (REPEAT_W+1)'(1);
    assign last_pulse = pcnt_nxt >= {1'b0, eff_repeat};

    assign armed = (state == ARMED);
    assign busy  = (state == DELAY) || (state == PULSE) || (state == GAP);

    always_ff @(posedge sc_clk or posedge sc_reset) begin
        if (sc_reset) begin
            state      <= IDLE;
            trig_q     <= 1'b0;
            glitch_out <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            pcnt       <= '0;
            eff_width  <= '0;
            eff_gap    <= '0;
            eff_repeat <= '0;
        end else begin
            trig_q <= trigger;
            done   <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                glitch_out <= 1'b0;
                cnt        <= '0;
                pcnt       <= '0;
            end else begin
                case (state)
                    IDLE: if (arm) state <= ARMED;
                    ARMED: if (trig_edge) begin
                        state      <= DELAY;
                        cnt        <= CNT_W'(delay_reg);
                        eff_width  <= width_c;
                        eff_gap    <= gap_c;
                        eff_repeat <= repeat_c;
                        pcnt       <= '0;
                    end
                    // Delay counts down to zero so a zero delay still costs one cycle.
                    DELAY: if (cnt == '0) begin
                        state      <= PULSE;
                        glitch_out <= 1'b1;
                        cnt        <= CNT_W'(eff_width);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    PULSE: if (cnt <= CNT_W'(1)) begin
                        glitch_out <= 1'b0;
                        if (last_pulse) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= GAP;
                            cnt   <= CNT_W'(eff_gap);
                            pcnt  <= pcnt_nxt[REPEAT_W-1:0];
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    GAP: if (cnt <= CNT_W'(1)) begin
                        state      <= PULSE;
                        glitch_out <= 1'b1;
                        cnt        <= CNT_W'(eff_width);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Randomised bench for glitch_pulse_gen against a pulse-train timing model.
module tb_glitch_pulse_gen;

    logic       sc_clk = 1'b0;
    logic       sc_reset, trigger, arm, abort, prog_shift, prog_bit;
    logic [1:0] prog_sel;
    logic       glitch_out, armed, busy, done;

    int checks = 0;
    int failures = 0;

    glitch_pulse_gen dut (
        .sc_clk     (sc_clk),
        .sc_reset   (sc_reset),
        .trigger    (trigger),
        .arm        (arm),
        .abort      (abort),
        .prog_shift (prog_shift),
        .prog_sel   (prog_sel),
        .prog_bit   (prog_bit),
        .glitch_out (glitch_out),
        .armed      (armed),
        .busy       (busy),
        .done       (done)
    );

    always #5 sc_clk = ~sc_clk;

    // Model: cycle k after the capturing edge is high if it falls inside
    // one of rep windows of length w, spaced w+g apart, starting at 1+d.
    function automatic bit model_high(int k, int d, int w, int g, int r);
        int kk;
        kk = k - 1 - d;
        if (kk < 0) return 1'b0;
        return ((kk / (w + g)) < r) && ((kk % (w + g)) < w);
    endfunction

    task automatic prog_reg(input logic [1:0] sel, input logic [31:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            prog_shift = 1'b1;
            prog_sel   = sel;
            prog_bit   = val[i];
            @(negedge sc_clk);
        end
        prog_shift = 1'b0;
    endtask

    task automatic prog_all(input int d, input int w, input int g, input int r);
        prog_reg(2'd0, d, 32);
        prog_reg(2'd1, w, 16);
        prog_reg(2'd2, g, 16);
        prog_reg(2'd3, r, 8);
    endtask

    task automatic arm_dut();
        arm = 1'b1;
        @(negedge sc_clk);
        arm = 1'b0;
        checks++;
        if (armed !== 1'b1) begin
            failures++;
            $display("FAIL arm_armed got=%b want=1", armed);
        end
    endtask

    // Fires an edge (DUT armed, trigger low) and checks the whole train.
    task automatic fire_train(input int d, input int w0, input int g0, input int r0,
                              input int retrig, input bit shift_busy);
        int w, g, r, done_k;
        w = (w0 == 0) ? 1 : w0;
        g = (g0 == 0) ? 1 : g0;
        r = (r0 == 0) ? 1 : r0;
        done_k = 1 + d + r * w + (r - 1) * g;
        repeat ($urandom_range(0, 3)) @(negedge sc_clk);
        trigger = 1'b1;
        @(negedge sc_clk);
        for (int k = 0; k <= done_k + 2; k++) begin
            checks++;
            if (glitch_out !== model_high(k, d, w, g, r)) begin
                failures++;
                $display("FAIL train_glitch d=%0d w=%0d g=%0d r=%0d k=%0d got=%b want=%b",
                         d, w, g, r, k, glitch_out, model_high(k, d, w, g, r));
            end
            checks++;
            if (done !== (k == done_k)) begin
                failures++;
                $display("FAIL train_done k=%0d got=%b want=%b", k, done, (k == done_k));
            end
            checks++;
            if (busy !== (k < done_k)) begin
                failures++;
                $display("FAIL train_busy k=%0d got=%b want=%b", k, busy, (k < done_k));
            end
            if (k == retrig) trigger = 1'b0;
            if (retrig >= 0 && k == retrig + 1) trigger = 1'b1;
            prog_shift = shift_busy && (k < done_k);
            prog_sel   = 2'd1;
            prog_bit   = 1'b1;
            @(negedge sc_clk);
        end
        prog_shift = 1'b0;
        trigger    = 1'b0;
        checks++;
        if (armed !== 1'b0) begin
            failures++;
            $display("FAIL train_end_armed got=%b want=0", armed);
        end
    endtask

    task automatic test_reset();
        sc_reset = 1'b1; trigger = 0; arm = 0; abort = 0;
        prog_shift = 0; prog_sel = 0; prog_bit = 0;
        #12;
        checks++;
        if ({glitch_out, armed, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0000", {glitch_out, armed, busy, done});
        end
        @(negedge sc_clk);
        sc_reset = 1'b0;
        @(negedge sc_clk);
    endtask

    task automatic test_defaults();
        arm_dut();
        fire_train(0, 4, 1, 1, -1, 1'b0);
    endtask

    task automatic test_program();
        prog_all(10, 3, 2, 3);
        arm_dut();
        fire_train(10, 3, 2, 3, -1, 1'b0);
    endtask

    task automatic test_clamp();
        prog_all(0, 0, 1, 0);
        arm_dut();
        fire_train(0, 0, 1, 0, -1, 1'b0);
        prog_all(2, 2, 0, 2);
        arm_dut();
        fire_train(2, 2, 0, 2, -1, 1'b0);
    endtask

    task automatic test_level_trigger();
        prog_all(1, 6, 1, 1);
        trigger = 1'b1;
        repeat (2) @(negedge sc_clk);
        arm_dut();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({glitch_out, busy, armed} !== 3'b001) begin
                failures++;
                $display("FAIL level_hold i=%0d got=%b want=001", i, {glitch_out, busy, armed});
            end
            @(negedge sc_clk);
        end
        trigger = 1'b0;
        @(negedge sc_clk);
        // Trigger re-pulses mid-PULSE; the train must be unaffected.
        fire_train(1, 6, 1, 1, 4, 1'b0);
    endtask

    task automatic test_abort();
        prog_all(0, 8, 1, 1);
        arm_dut();
        trigger = 1'b1;
        @(negedge sc_clk);
        repeat (3) @(negedge sc_clk);
        checks++;
        if (glitch_out !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre got=%b want=1", glitch_out);
        end
        abort = 1'b1;
        @(negedge sc_clk);
        abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({glitch_out, busy, armed, done} !== 4'b0000) begin
                failures++;
                $display("FAIL abort_post i=%0d got=%b want=0000", i, {glitch_out, busy, armed, done});
            end
            @(negedge sc_clk);
        end
        trigger = 1'b0;
        @(negedge sc_clk);
        arm_dut();
        fire_train(0, 8, 1, 1, -1, 1'b0);
    endtask

    task automatic test_shift_while_busy();
        prog_all(5, 3, 1, 2);
        arm_dut();
        fire_train(5, 3, 1, 2, -1, 1'b1);
        arm_dut();
        fire_train(5, 3, 1, 2, -1, 1'b0);
    endtask

    task automatic test_async_reset();
        prog_all(20, 2, 3, 2);
        arm_dut();
        trigger = 1'b1;
        @(negedge sc_clk);
        repeat (3) @(negedge sc_clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre busy got=%b want=1", busy);
        end
        #2 sc_reset = 1'b1;
        #1;
        checks++;
        if ({glitch_out, armed, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL areset_async got=%b want=0000", {glitch_out, armed, busy, done});
        end
        @(negedge sc_clk);
        sc_reset = 1'b0;
        trigger  = 1'b0;
        @(negedge sc_clk);
        arm_dut();
        fire_train(0, 4, 1, 1, -1, 1'b0);
    endtask

    task automatic test_random();
        int d, w, g, r;
        for (int n = 0; n < 8; n++) begin
            d = $urandom_range(0, 12);
            w = $urandom_range(0, 5);
            g = $urandom_range(0, 4);
            r = $urandom_range(0, 4);
            prog_all(d, w, g, r);
            arm_dut();
            fire_train(d, w, g, r, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_program();
        test_clamp();
        test_level_trigger();
        test_abort();
        test_shift_while_busy();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glitch_pulse_gen.md
Name: glitch_pulse_gen

Overview:
Downstream stage of the edge-counting trigger block. It consumes that block's level `trigger` output in the `sc_clk` domain. When armed, a trigger rising edge starts a programmable delay, followed by a train of glitch pulses on `glitch_out` (delay, width, repeat count and inter-pulse gap). The four timing registers are loaded over a serial shift interface that is sampled in the same clock domain.

Parameters:
DELAY_W, 32, width of delay register/counter
WIDTH_W, 16, width of pulse-width and gap registers/counters
REPEAT_W, 8, width of repeat-count register/counter
DEF_DELAY, 0, delay register reset value
DEF_WIDTH, 4, pulse-width register reset value
DEF_GAP, 1, gap register reset value
DEF_REPEAT, 1, repeat register reset value

Ports:
sc_clk  in  1  sole clock
sc_reset  in  1  asynchronous reset, active-high
trigger  in  1  level trigger from upstream counter block, sc_clk-synchronous
arm  in  1  one-cycle strobe, arms block from IDLE
abort  in  1  one-cycle strobe, returns to IDLE from any state
prog_shift  in  1  shift-enable for the programming interface
prog_sel  in  2  0=delay, 1=width, 2=gap, 3=repeat
prog_bit  in  1  serial data bit, MSB first
glitch_out  out  1  glitch pulse output, registered
armed  out  1  high in ARMED
busy  out  1  high in DELAY/PULSE/GAP
done  out  1  one-cycle pulse after last pulse ends

Behaviour:
- Reset (async, active-high):
  - FSM=IDLE; glitch_out, armed, busy, done = 0; all counters 0.
  - Timing registers = DEF_* values; trigger edge-detect register = 0.
- Programming:
  - On a cycle with prog_shift=1 in IDLE, the selected register <= {reg[W-2:0], prog_bit}.
  - prog_shift outside IDLE is ignored; registers hold.
- Edge detect:
  - trig_q <= trigger each cycle.
  - An edge is trigger=1 && trig_q=0. Level-high trigger never retriggers.
- FSM states: IDLE, ARMED, DELAY, PULSE, GAP.
  - IDLE -> ARMED on arm.
  - ARMED -> DELAY on edge; the internal `eff_*` values below are latched at that moment.
  - DELAY counts eff_delay cycles, then -> PULSE. eff_delay=0 means PULSE on the next edge.
  - PULSE holds glitch_out=1 for exactly eff_width cycles.
  - After PULSE: if pulses emitted < eff_repeat -> GAP; else -> IDLE with done=1 for one cycle.
  - GAP holds glitch_out=0 for eff_gap cycles, then -> PULSE.
- Clamping:
  - width=0, gap=0 and repeat=0 are each treated as 1.
  - delay=0 is legal.
- Latency: if the edge is detected at clock edge T, glitch_out rises at edge T+1+delay and falls at edge T+1+delay+width.
- Latched parameters: eff_delay, eff_width, eff_gap and eff_repeat are captured on the edge. They cannot change mid-train, since programming is blocked outside IDLE anyway.
- Simultaneous events:
  - abort has priority over everything: -> IDLE next edge, glitch_out=0 next edge, done not asserted.
  - arm outside IDLE is ignored.
  - Trigger edges outside ARMED are ignored.
  - arm and an edge in the same IDLE cycle: arm only; the edge is not captured.
- Counters saturate: no wrap-around. Down-counters load the value and terminate at 1.
- glitch_out is a flop output (glitch-free). busy and armed decode from the state register.

Decomposition:
- Shared package `glitch_pkg`: state enum (IDLE/ARMED/DELAY/PULSE/GAP), prog_sel encodings (SEL_DELAY=0, SEL_WIDTH=1, SEL_GAP=2, SEL_REPEAT=3), default widths.
- One sub-module `glitch_prog_regs`: the four shift-loaded timing registers with IDLE-gated shift enable.
- FSM and counters stay in the top module.

Test Plan:
- Reset defaults, arm, trigger edge at T -> glitch_out high edges T+1..T+4 (width 4), done at T+5, state IDLE.
- Program delay=10, width=3, gap=2, repeat=3 via 32/16/16/8 serial shifts; arm; edge at T -> pulses at [T+11,T+14), [T+16,T+19), [T+21,T+24); done at T+24.
- Program width=0, repeat=0 -> exactly one 1-cycle pulse; gap=0 with repeat=2 -> 1-cycle low between pulses.
- Trigger held high before arm, then arm -> no pulse until trigger falls and rises again. A second edge during PULSE has no effect.
- abort mid-PULSE -> glitch_out 0 next edge, no done, arm works again. prog_shift during busy leaves registers unchanged (read back via a subsequent train).
- Assert sc_reset asynchronously mid-DELAY -> outputs 0 immediately without waiting for a clock edge; registers return to DEF_* values.
